// File: rtl/dmi_req_arb.sv
// dmi_req_arb: two-requester round-robin arbiter in front of a shared DMI
// request/response channel pair, one transaction in flight, with timeout.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reqN_vld/pld/rdy  requester N request channel, payload {addr, data, op}
//   rspN_vld/pld/rdy  requester N response channel, payload {data, resp}
//   dmi_req_*         shared request channel toward the DMI CDC FIFO
//   dmi_rsp_*         shared response channel from the DMI CDC FIFO
//   busy              transaction in flight or a stale response pending
module dmi_req_arb #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  localparam int RQW = ADDR_WIDTH + DATA_WIDTH + 2,
  localparam int RSW = DATA_WIDTH + 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_vld,
  input  logic [RQW-1:0] req0_pld,
  output logic           req0_rdy,
  output logic           rsp0_vld,
  output logic [RSW-1:0] rsp0_pld,
  input  logic           rsp0_rdy,
  input  logic           req1_vld,
  input  logic [RQW-1:0] req1_pld,
  output logic           req1_rdy,
  output logic           rsp1_vld,
  output logic [RSW-1:0] rsp1_pld,
  input  logic           rsp1_rdy,
  output logic           dmi_req_vld,
  output logic [RQW-1:0] dmi_req_pld,
  input  logic           dmi_req_rdy,
  input  logic           dmi_rsp_vld,
  input  logic [RSW-1:0] dmi_rsp_pld,
  output logic           dmi_rsp_rdy,
  output logic           busy
);

  // TIMEOUT=0 would give a zero-width counter; keep one idle bit.
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RSW-1:0] RSP_TMO =
    {{DATA_WIDTH{1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } state_e;

  state_e         state_q;
  logic           gnt_q;
  logic           last_gnt_q;
  logic           stale_q;
  logic [CW-1:0]  cnt_q;
  logic [RQW-1:0] req_q;
  logic [RSW-1:0] rsp_q;

  logic gnt_d;
  logic can_gnt;
  logic rsp_hs;
  logic tmo_hit;

  // Both valid: the one that did not win last time. Else the valid one.
  assign gnt_d = (req0_vld && req1_vld) ? ~last_gnt_q : req1_vld;
  assign can_gnt = (state_q == IDLE) && !stale_q;

  assign req0_rdy = can_gnt && req0_vld && !gnt_d;
  assign req1_rdy = can_gnt && req1_vld && gnt_d;

  assign dmi_req_vld = (state_q == SEND);
  assign dmi_req_pld = req_q;

  // A stale response is drained while idle so it cannot be
  // mistaken for the answer to the next request.
  assign dmi_rsp_rdy = (state_q == WAIT) ||
                       ((state_q == IDLE) && stale_q);

  assign rsp0_vld = (state_q == RESP) && !gnt_q;
  assign rsp1_vld = (state_q == RESP) && gnt_q;
  assign rsp0_pld = rsp_q;
  assign rsp1_pld = rsp_q;

  assign rsp_hs  = gnt_q ? rsp1_rdy : rsp0_rdy;
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  assign busy = (state_q != IDLE) || stale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      stale_q    <= 1'b0;
      cnt_q      <= '0;
      req_q      <= '0;
      rsp_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stale_q) begin
            if (dmi_rsp_vld) stale_q <= 1'b0;
          end else if (req0_vld || req1_vld) begin
            gnt_q   <= gnt_d;
            req_q   <= gnt_d ? req1_pld : req0_pld;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (dmi_req_rdy) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A response in the timeout cycle takes priority.
          if (dmi_rsp_vld) begin
            rsp_q   <= dmi_rsp_pld;
            state_q <= RESP;
          end else if (tmo_hit) begin
            rsp_q   <= RSP_TMO;
            stale_q <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_hs) begin
            last_gnt_q <= gnt_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_req_arb.sv
// tb_dmi_req_arb: directed stimulus for dmi_req_arb with a transaction-level
// reference model compared every cycle, plus hand-computed spot values.
module tb_dmi_req_arb;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int RQW = AW + DW + 2;
  localparam int RSW = DW + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_vld, req0_rdy;
  logic [RQW-1:0] req0_pld;
  logic           rsp0_vld, rsp0_rdy;
  logic [RSW-1:0] rsp0_pld;
  logic           req1_vld, req1_rdy;
  logic [RQW-1:0] req1_pld;
  logic           rsp1_vld, rsp1_rdy;
  logic [RSW-1:0] rsp1_pld;
  logic           dmi_req_vld, dmi_req_rdy;
  logic [RQW-1:0] dmi_req_pld;
  logic           dmi_rsp_vld, dmi_rsp_rdy;
  logic [RSW-1:0] dmi_rsp_pld;
  logic           busy;

  dmi_req_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_vld(req0_vld),
    .req0_pld(req0_pld),
    .req0_rdy(req0_rdy),
    .rsp0_vld(rsp0_vld),
    .rsp0_pld(rsp0_pld),
    .rsp0_rdy(rsp0_rdy),
    .req1_vld(req1_vld),
    .req1_pld(req1_pld),
    .req1_rdy(req1_rdy),
    .rsp1_vld(rsp1_vld),
    .rsp1_pld(rsp1_pld),
    .rsp1_rdy(rsp1_rdy),
    .dmi_req_vld(dmi_req_vld),
    .dmi_req_pld(dmi_req_pld),
    .dmi_req_rdy(dmi_req_rdy),
    .dmi_rsp_vld(dmi_rsp_vld),
    .dmi_rsp_pld(dmi_rsp_pld),
    .dmi_rsp_rdy(dmi_rsp_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one in-flight record plus a stale flag.
  bit             m_ok;
  bit             m_txn, m_sent, m_ans, m_stale;
  int             m_who, m_last, m_wait;
  logic [RQW-1:0] m_req;
  logic [RSW-1:0] m_rsp;
  int             gq[$];
  logic [RSW:0]   rq[$];

  initial begin : model
    int win;
    bit any;
    m_ok = 0;
    forever begin
      @(negedge clk);
      any = req0_vld || req1_vld;
      if (req0_vld && req1_vld) win = 1 - m_last;
      else win = req1_vld ? 1 : 0;
      if (m_ok) begin
        chk("req0_rdy", req0_rdy,
            !m_txn && !m_stale && req0_vld && win == 0);
        chk("req1_rdy", req1_rdy,
            !m_txn && !m_stale && req1_vld && win == 1);
        chk("dmi_req_vld", dmi_req_vld, m_txn && !m_sent);
        chk("dmi_rsp_rdy", dmi_rsp_rdy,
            (m_txn && m_sent && !m_ans) || (!m_txn && m_stale));
        chk("rsp0_vld", rsp0_vld, m_txn && m_ans && m_who == 0);
        chk("rsp1_vld", rsp1_vld, m_txn && m_ans && m_who == 1);
        chk("busy", busy, m_txn || m_stale);
        if (m_txn && !m_sent) chk("dmi_req_pld", dmi_req_pld, m_req);
        if (m_txn && m_ans && m_who == 0) chk("rsp0_pld", rsp0_pld, m_rsp);
        if (m_txn && m_ans && m_who == 1) chk("rsp1_pld", rsp1_pld, m_rsp);
      end
      if (!rst) begin
        if (req0_vld && req0_rdy) gq.push_back(0);
        if (req1_vld && req1_rdy) gq.push_back(1);
        if (rsp0_vld && rsp0_rdy) rq.push_back({1'b0, rsp0_pld});
        if (rsp1_vld && rsp1_rdy) rq.push_back({1'b1, rsp1_pld});
      end
      if (rst) begin
        m_ok = 1; m_txn = 0; m_sent = 0; m_ans = 0;
        m_stale = 0; m_last = 1; m_who = 0; m_wait = 0;
      end else if (m_ok) begin
        if (!m_txn) begin
          if (m_stale) begin
            if (dmi_rsp_vld) m_stale = 0;
          end else if (any) begin
            m_txn = 1; m_sent = 0; m_ans = 0; m_who = win;
            m_req = (win == 1) ? req1_pld : req0_pld;
          end
        end else if (!m_sent) begin
          if (dmi_req_rdy) begin m_sent = 1; m_wait = 0; end
        end else if (!m_ans) begin
          if (dmi_rsp_vld) begin
            m_rsp = dmi_rsp_pld; m_ans = 1;
          end else if (m_wait == TO - 1) begin
            m_rsp = {{DW{1'b0}}, 2'b11}; m_ans = 1; m_stale = 1;
          end else begin
            m_wait++;
          end
        end else if ((m_who == 0 && rsp0_rdy) ||
                     (m_who == 1 && rsp1_rdy)) begin
          m_txn = 0; m_last = m_who;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic all_zero(string nm);
    chk(nm, {req0_rdy, req1_rdy, dmi_req_vld, dmi_rsp_rdy,
             rsp0_vld, rsp1_vld, busy}, 0);
  endtask

  initial begin : stim
    int w;
    logic [RSW:0] e;
    rst = 1; req0_vld = 0; req1_vld = 0;
    req0_pld = '0; req1_pld = '0;
    rsp0_rdy = 1; rsp1_rdy = 1;
    dmi_req_rdy = 1; dmi_rsp_vld = 0; dmi_rsp_pld = '0;
    step(2);
    rst = 0;
    all_zero("reset_outputs");

    // Single read from requester 0.
    req0_vld = 1; req0_pld = {7'h11, 32'h0, 2'b01};
    step(1);
    chk("rd_send_vld", dmi_req_vld, 1);
    chk("rd_send_pld", dmi_req_pld, {7'h11, 32'h0, 2'b01});
    req0_vld = 0;
    step(1);
    step(3);
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'hCAFE_F00D, 2'b00};
    step(1);
    dmi_rsp_vld = 0;
    chk("rd_rsp0_vld", rsp0_vld, 1);
    chk("rd_rsp0_pld", rsp0_pld, {32'hCAFE_F00D, 2'b00});
    chk("rd_rsp1_vld", rsp1_vld, 0);
    step(1);
    chk("rd_busy_end", busy, 0);

    // Backpressure on the DMI request side, then on the response side.
    dmi_req_rdy = 0;
    req0_vld = 1; req0_pld = {7'h05, 32'h1111_2222, 2'b10};
    step(1);
    req0_vld = 0;
    req1_vld = 1; req1_pld = {7'h06, 32'h3333_4444, 2'b01};
    step(5);
    chk("bp_req_vld", dmi_req_vld, 1);
    chk("bp_req_pld", dmi_req_pld, {7'h05, 32'h1111_2222, 2'b10});
    chk("bp_req1_blk", req1_rdy, 0);
    dmi_req_rdy = 1;
    step(1);
    rsp0_rdy = 0;
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'h5555_6666, 2'b00};
    step(1);
    dmi_rsp_vld = 0;
    step(5);
    chk("bp_rsp0_vld", rsp0_vld, 1);
    chk("bp_rsp0_pld", rsp0_pld, {32'h5555_6666, 2'b00});
    chk("bp_req1_blk2", req1_rdy, 0);
    rsp0_rdy = 1;
    step(1);
    chk("bp_req1_gnt", req1_rdy, 1);
    step(1);
    req1_vld = 0;
    step(1);
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'h0000_BEEF, 2'b00};
    step(1);
    dmi_rsp_vld = 0;
    chk("bp_rsp1_vld", rsp1_vld, 1);
    step(1);

    // Timeout with no DMI response; late response is drained.
    req0_vld = 1; req0_pld = {7'h40, 32'h0, 2'b01};
    step(1);
    req0_vld = 0;
    step(1);
    w = cyc;
    req1_vld = 1; req1_pld = {7'h41, 32'h0, 2'b01};
    for (int i = 0; i < 20 && !rsp0_vld; i++) step(1);
    chk("tmo_latency", cyc - w, 8);
    chk("tmo_rsp0_vld", rsp0_vld, 1);
    chk("tmo_rsp0_pld", rsp0_pld, 34'h3);
    step(1);
    chk("tmo_busy_stale", busy, 1);
    chk("tmo_drain_rdy", dmi_rsp_rdy, 1);
    chk("tmo_req1_blk", req1_rdy, 0);
    step(3);
    chk("tmo_req1_blk2", req1_rdy, 0);
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'hDEAD_0000, 2'b00};
    step(1);
    dmi_rsp_vld = 0;
    chk("late_no_rsp", {rsp0_vld, rsp1_vld}, 0);
    chk("late_req1_gnt", req1_rdy, 1);
    step(1);
    req1_vld = 0;
    step(1);
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'h0000_0041, 2'b00};
    step(1);
    dmi_rsp_vld = 0;
    step(1);

    // Response lands in the very cycle the timeout would fire.
    req0_vld = 1; req0_pld = {7'h50, 32'h0, 2'b01};
    step(1);
    req0_vld = 0;
    step(1);
    step(TO - 1);
    dmi_rsp_vld = 1; dmi_rsp_pld = {32'h1234_5678, 2'b10};
    step(1);
    dmi_rsp_vld = 0;
    chk("race_rsp0_pld", rsp0_pld, {32'h1234_5678, 2'b10});
    step(1);
    chk("race_no_stale", {busy, dmi_rsp_rdy}, 0);

    // Reset while waiting on the DMI.
    req1_vld = 1; req1_pld = {7'h60, 32'h0, 2'b01};
    step(1);
    req1_vld = 0;
    step(3);
    rst = 1;
    step(1);
    rst = 0;
    all_zero("rst_wait_outputs");

    // Continuous contention: 4 transactions.
    gq.delete();
    rq.delete();
    req0_vld = 1; req0_pld = {7'h20, 32'hA0, 2'b01};
    req1_vld = 1; req1_pld = {7'h21, 32'hB1, 2'b10};
    for (int t = 0; t < 4; t++) begin
      step(2);
      dmi_rsp_vld = 1;
      dmi_rsp_pld = {32'hD000_0000 + 32'(t), 2'b00};
      step(1);
      dmi_rsp_vld = 0;
      if (t == 3) begin
        req0_vld = 0; req1_vld = 0;
      end
      step(1);
    end
    chk("cont_gnt_count", gq.size(), 4);
    chk("cont_rsp_count", rq.size(), 4);
    for (int t = 0; t < 4; t++) begin
      chk("cont_gnt_order", (t < gq.size()) ? gq[t] : -1, t % 2);
      e = {t[0], 32'hD000_0000 + 32'(t), 2'b00};
      chk("cont_rsp_route", (t < rq.size()) ? rq[t] : '1, e);
    end
    step(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
